// File: rtl/im2col_idx_gen_pkg.sv
// Shared types for the im2col index generator and the downstream address converter.
package im2col_pkg;

   localparam int IDX_W_DEF = 16;
   localparam int CNT_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   // One emitted coordinate, shared with the address converter.
   typedef struct packed {
      logic [IDX_W_DEF-1:0] Bx;
      logic [IDX_W_DEF-1:0] By;
      logic                 oob;
      logic                 last;
   } coord_t;

endpackage

// File: rtl/im2col_idx_gen_if.sv
// Coordinate stream between the index generator (master) and the address converter (slave).
interface im2col_idx_if
   import im2col_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF
);
   logic [IDX_W-1:0] Bx;
   logic [IDX_W-1:0] By;
   logic             oob;
   logic             last;
   logic             idx_valid;
   logic             idx_ready;

   modport master (output Bx, By, oob, last, idx_valid, input idx_ready);
   modport slave  (input Bx, By, oob, last, idx_valid, output idx_ready);
endinterface

// File: rtl/im2col_walk_cnt.sv
// 2-D wrapping tile counter: Bx is the inner loop, By the outer loop.
// Coordinates carry one extra bit so base+extent never wraps silently.
module im2col_walk_cnt #(
   parameter int IDX_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [IDX_W-1:0] bx_base,
   input  logic [IDX_W-1:0] by_base,
   input  logic [IDX_W-1:0] bx_cnt,
   input  logic [IDX_W-1:0] by_cnt,
   output logic [IDX_W:0]   bx,
   output logic [IDX_W:0]   by,
   output logic             wrap,
   output logic             last_row
);
   localparam int CW = IDX_W + 1;

   logic [CW-1:0] bx_q, bx_d;
   logic [CW-1:0] by_q, by_d;
   logic [CW-1:0] bx_start_q, bx_start_d;
   logic [CW-1:0] bx_end_q, bx_end_d;
   logic [CW-1:0] by_end_q, by_end_d;

   assign wrap     = (bx_q == bx_end_q);
   assign last_row = (by_q == by_end_q);
   assign bx       = bx_q;
   assign by       = by_q;

   // End points are only meaningful for non-zero extents; the FSM never walks otherwise.
   always_comb begin
      bx_d       = bx_q;
      by_d       = by_q;
      bx_start_d = bx_start_q;
      bx_end_d   = bx_end_q;
      by_end_d   = by_end_q;
      if (load) begin
         bx_d       = {1'b0, bx_base};
         by_d       = {1'b0, by_base};
         bx_start_d = {1'b0, bx_base};
         bx_end_d   = {1'b0, bx_base} + {1'b0, bx_cnt} - CW'(1);
         by_end_d   = {1'b0, by_base} + {1'b0, by_cnt} - CW'(1);
      end else if (step) begin
         if (wrap) begin
            bx_d = bx_start_q;
            by_d = by_q + CW'(1);
         end else begin
            bx_d = bx_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bx_q       <= '0;
         by_q       <= '0;
         bx_start_q <= '0;
         bx_end_q   <= '0;
         by_end_q   <= '0;
      end else begin
         bx_q       <= bx_d;
         by_q       <= by_d;
         bx_start_q <= bx_start_d;
         bx_end_q   <= bx_end_d;
         by_end_q   <= by_end_d;
      end
   end
endmodule

// File: rtl/im2col_idx_gen.sv
// im2col index generator: walks one tile of the im2col matrix and streams (Bx, By)
// coordinates with out-of-bounds and last flags over a valid/ready handshake.
module im2col_idx_gen
   import im2col_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDX_W-1:0] bx_base,
   input  logic [IDX_W-1:0] by_base,
   input  logic [IDX_W-1:0] bx_cnt,
   input  logic [IDX_W-1:0] by_cnt,
   input  logic [IDX_W-1:0] bx_lim,
   input  logic [IDX_W-1:0] by_lim,
   output logic [CNT_W-1:0] elem_cnt,
   output logic             busy,
   output logic             done,
   im2col_idx_if.master     idx
);
   state_t           state_q, state_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] elem_cnt_q, elem_cnt_d;
   logic [IDX_W-1:0] bx_lim_q, bx_lim_d;
   logic [IDX_W-1:0] by_lim_q, by_lim_d;

   logic [IDX_W:0]   cur_bx;
   logic [IDX_W:0]   cur_by;
   logic             walk_wrap;
   logic             walk_last_row;
   logic             tile_last;
   logic             hs;
   logic             accept;
   logic             zero_extent;

   assign hs          = valid_q && idx.idx_ready;
   assign accept      = start && (state_q == IDLE);
   assign zero_extent = (bx_cnt == '0) || (by_cnt == '0);
   assign tile_last   = walk_wrap && walk_last_row;

   im2col_walk_cnt #(.IDX_W(IDX_W)) u_walk (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .step     (hs && !tile_last),
      .bx_base  (bx_base),
      .by_base  (by_base),
      .bx_cnt   (bx_cnt),
      .by_cnt   (by_cnt),
      .bx       (cur_bx),
      .by       (cur_by),
      .wrap     (walk_wrap),
      .last_row (walk_last_row)
   );

   // FIN holds for two cycles after a zero-extent start (done in the second) and one
   // cycle after a walk; done_q tells the two cases apart.
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      elem_cnt_d = elem_cnt_q;
      bx_lim_d   = bx_lim_q;
      by_lim_d   = by_lim_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               bx_lim_d   = bx_lim;
               by_lim_d   = by_lim;
               elem_cnt_d = '0;
               if (zero_extent) begin
                  state_d = FIN;
               end else begin
                  state_d = RUN;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
               end
            end
         end
         RUN: begin
            if (hs) begin
               elem_cnt_d = elem_cnt_q + CNT_W'(1);
               if (tile_last) begin
                  state_d = FIN;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         FIN: begin
            if (done_q) state_d = IDLE;
            else        done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         elem_cnt_q <= '0;
         bx_lim_q   <= '0;
         by_lim_q   <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         elem_cnt_q <= elem_cnt_d;
         bx_lim_q   <= bx_lim_d;
         by_lim_q   <= by_lim_d;
      end
   end

   // The wide compare also flags any coordinate that overflowed into bit IDX_W.
   assign idx.oob       = valid_q && ((cur_bx >= {1'b0, bx_lim_q}) || (cur_by >= {1'b0, by_lim_q}));
   assign idx.last      = valid_q && tile_last;
   assign idx.Bx        = cur_bx[IDX_W-1:0];
   assign idx.By        = cur_by[IDX_W-1:0];
   assign idx.idx_valid = valid_q;
   assign elem_cnt      = elem_cnt_q;
   assign busy          = busy_q;
   assign done          = done_q;
endmodule

// File: tb/tb_im2col_idx_gen.sv
// Scoreboard bench for im2col_idx_gen: a nested-loop tile model feeds an expected queue,
// a negedge monitor pops and compares on every handshake.
module tb_im2col_idx_gen;
   localparam int IDX_W = 16;
   localparam int CNT_W = 32;

   typedef struct {
      logic [15:0] bx;
      logic [15:0] by;
      logic        oob;
      logic        last;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [IDX_W-1:0] bx_base = '0, by_base = '0, bx_cnt = '0, by_cnt = '0;
   logic [IDX_W-1:0] bx_lim = '0, by_lim = '0;
   logic [CNT_W-1:0] elem_cnt;
   logic             busy, done;

   im2col_idx_if #(.IDX_W(IDX_W)) ifc ();

   im2col_idx_gen #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bx_base  (bx_base),
      .by_base  (by_base),
      .bx_cnt   (bx_cnt),
      .by_cnt   (by_cnt),
      .bx_lim   (bx_lim),
      .by_lim   (by_lim),
      .elem_cnt (elem_cnt),
      .busy     (busy),
      .done     (done),
      .idx      (ifc)
   );

   always #5 clk = ~clk;

   exp_t expQ[$];
   bit   readyPat[$];
   bit   pendingPat[$];
   bit   readyRandom = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   tileHs = 0;
   bit   doneDue = 1'b0;
   bit   allowDone = 1'b0;
   bit   prevStall = 1'b0;
   exp_t held;

   task automatic checkOutput(input string name, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference: every coordinate of the tile in By-major order, with oob from plain integer compares.
   function automatic void modelTile(int bxb, int byb, int bxc, int byc, int bxl, int byl);
      for (int y = 0; y < byc; y++) begin
         for (int x = 0; x < bxc; x++) begin
            exp_t e;
            int   cx, cy;
            cx     = bxb + x;
            cy     = byb + y;
            e.bx   = cx[15:0];
            e.by   = cy[15:0];
            e.oob  = (cx >= bxl) || (cy >= byl);
            e.last = (x == bxc - 1) && (y == byc - 1);
            expQ.push_back(e);
         end
      end
   endfunction

   task automatic applyStimulus(input int bxb, input int byb, input int bxc, input int byc,
                                input int bxl, input int byl);
      @(posedge clk); #1;
      bx_base = bxb[15:0]; by_base = byb[15:0];
      bx_cnt  = bxc[15:0]; by_cnt  = byc[15:0];
      bx_lim  = bxl[15:0]; by_lim  = byl[15:0];
      modelTile(bxb, byb, bxc, byc, bxl, byl);
      tileHs = 0;
      start  = 1'b1;
      @(negedge clk);
      while (pendingPat.size() > 0) readyPat.push_back(pendingPat.pop_front());
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input int expCount, output int waited);
      bit seen = 1'b0;
      waited = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk); #1;
         waited = i + 1;
         if (done) seen = 1'b1;
      end
      checkOutput("done_seen", seen, 1);
      checkOutput("elem_cnt_final", elem_cnt, expCount);
      checkOutput("queue_drained", expQ.size(), 0);
      expQ.delete();
   endtask

   // Ready driver: scripted pattern first, then random or always-ready.
   initial begin
      ifc.idx_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (readyPat.size() > 0)  ifc.idx_ready = readyPat.pop_front();
         else if (readyRandom)     ifc.idx_ready = 1'($urandom_range(0, 1));
         else                      ifc.idx_ready = 1'b1;
      end
   end

   // Monitor: handshake pending at a negedge completes at the next posedge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            doneDue   = 1'b0;
            prevStall = 1'b0;
         end else begin
            if (doneDue) begin
               checkOutput("done_after_last", done, 1);
               checkOutput("valid_low_after_last", ifc.idx_valid, 0);
               doneDue = 1'b0;
            end else if (!allowDone) begin
               checkOutput("no_spurious_done", done, 0);
            end
            if (prevStall) begin
               checkOutput("stall_valid_held", ifc.idx_valid, 1);
               checkOutput("stall_bx_held", ifc.Bx, held.bx);
               checkOutput("stall_by_held", ifc.By, held.by);
               checkOutput("stall_oob_held", ifc.oob, held.oob);
               checkOutput("stall_last_held", ifc.last, held.last);
            end
            if (ifc.idx_valid && ifc.idx_ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_coordinate", ifc.idx_valid, 0);
               end else begin
                  exp_t e;
                  e = expQ.pop_front();
                  checkOutput("coord_bx", ifc.Bx, e.bx);
                  checkOutput("coord_by", ifc.By, e.by);
                  checkOutput("coord_oob", ifc.oob, e.oob);
                  checkOutput("coord_last", ifc.last, e.last);
                  checkOutput("elem_cnt_running", elem_cnt, tileHs);
                  if (e.last) doneDue = 1'b1;
               end
               tileHs++;
            end
            prevStall = ifc.idx_valid && !ifc.idx_ready;
            held.bx   = ifc.Bx;
            held.by   = ifc.By;
            held.oob  = ifc.oob;
            held.last = ifc.last;
         end
      end
   end

   initial begin
      int waited;
      int bxc, byc;
      #23;
      checkOutput("reset_valid", ifc.idx_valid, 0);
      checkOutput("reset_bx", ifc.Bx, 0);
      checkOutput("reset_by", ifc.By, 0);
      checkOutput("reset_oob", ifc.oob, 0);
      checkOutput("reset_last", ifc.last, 0);
      checkOutput("reset_elem_cnt", elem_cnt, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      rst = 1'b0;

      $display("[TB] full 3x2 walk");
      applyStimulus(0, 0, 3, 2, 2400, 729);
      @(negedge clk); #1;
      checkOutput("first_valid_latency", ifc.idx_valid, 1);
      checkOutput("busy_running", busy, 1);
      waitDone(6, waited);
      checkOutput("walk_cycles", waited, 6);

      $display("[TB] Bx edge clipping");
      applyStimulus(2398, 728, 4, 1, 2400, 729);
      waitDone(4, waited);

      $display("[TB] backpressure 1,0,0,1,1");
      pendingPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      applyStimulus(0, 0, 3, 2, 2400, 729);
      @(negedge clk); #1;
      checkOutput("bp_first_valid", ifc.idx_valid, 1);
      waitDone(6, waited);
      checkOutput("bp_walk_cycles", waited, 8);

      $display("[TB] zero extent");
      for (int k = 0; k < 2; k++) begin
         allowDone = 1'b1;
         applyStimulus(5, 5, (k == 0) ? 0 : 3, (k == 0) ? 3 : 0, 2400, 729);
         @(negedge clk); #1;
         checkOutput("zero_done_not_yet", done, 0);
         checkOutput("zero_valid_low", ifc.idx_valid, 0);
         @(negedge clk); #1;
         checkOutput("zero_done_pulse", done, 1);
         checkOutput("zero_valid_still_low", ifc.idx_valid, 0);
         checkOutput("zero_elem_cnt", elem_cnt, 0);
         checkOutput("zero_busy", busy, 0);
         @(negedge clk); #1;
         checkOutput("zero_done_single", done, 0);
         allowDone = 1'b0;
      end

      $display("[TB] start ignored while busy and in FIN");
      applyStimulus(0, 0, 3, 2, 2400, 729);
      @(negedge clk);
      @(posedge clk); #1;
      bx_base = 16'd100; by_base = 16'd50; bx_cnt = 16'd1; by_cnt = 16'd1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      waitDone(6, waited);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      checkOutput("start_in_fin_ignored", ifc.idx_valid, 0);
      checkOutput("start_in_fin_not_busy", busy, 0);

      $display("[TB] reset mid-walk");
      applyStimulus(0, 0, 3, 2, 2400, 729);
      for (int i = 0; i < 50 && tileHs < 2; i++) begin
         @(negedge clk); #1;
      end
      checkOutput("reached_two_handshakes", tileHs, 2);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_valid", ifc.idx_valid, 0);
      checkOutput("rst_bx", ifc.Bx, 0);
      checkOutput("rst_by", ifc.By, 0);
      checkOutput("rst_elem_cnt", elem_cnt, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      expQ.delete();
      repeat (2) @(negedge clk);
      #3 rst = 1'b0;
      repeat (3) @(negedge clk);
      applyStimulus(0, 0, 3, 2, 2400, 729);
      waitDone(6, waited);

      $display("[TB] 16-bit overflow boundary");
      applyStimulus(16'hFFFE, 0, 4, 1, 65535, 10);
      waitDone(4, waited);

      $display("[TB] random tiles with random ready");
      readyRandom = 1'b1;
      for (int t = 0; t < 12; t++) begin
         bxc = $urandom_range(1, 5);
         byc = $urandom_range(1, 4);
         applyStimulus($urandom_range(0, 40), $urandom_range(0, 40), bxc, byc,
                       $urandom_range(1, 45), $urandom_range(1, 45));
         waitDone(bxc * byc, waited);
      end
      readyRandom = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
